// File: rtl/audio_delay_if.sv
// Sample/control bundle between the trim controller, audio path and delay engine.
// master drives strobe, mode, gains and input sample; slave returns output and status.
interface audio_delay_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int TAPS   = 2,
    parameter int GAIN_W = 8
);
    logic                     adc_clock;
    logic [1:0]               mode;
    logic [ADDR_W-1:0]        delay_len;
    logic [GAIN_W-1:0]        fb_gain;
    logic [TAPS*GAIN_W-1:0]   tap_gain;
    logic [DATA_W-1:0]        data_in;
    logic [DATA_W-1:0]        data_out;
    logic                     out_valid;
    logic                     busy;
    logic [ADDR_W:0]          loop_len;
    logic                     loop_full;
    logic                     overrun;

    modport master (
        output adc_clock, mode, delay_len, fb_gain, tap_gain, data_in,
        input  data_out, out_valid, busy, loop_len, loop_full, overrun
    );

    modport slave (
        input  adc_clock, mode, delay_len, fb_gain, tap_gain, data_in,
        output data_out, out_valid, busy, loop_len, loop_full, overrun
    );
endinterface

// File: rtl/audio_delay_engine.sv
// Per-sample bypass / multi-tap feedback delay / loop record / loop play engine.
// Ports: clk, rst (sync, active high), bus (audio_delay_if.slave: strobe, controls, sample out, status).
module audio_delay_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int TAPS   = 2,
    parameter int GAIN_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    audio_delay_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int ACC_W = DATA_W + 3;
    localparam int PW    = DATA_W + GAIN_W + 1;
    localparam logic [1:0] M_BYP = 2'd0, M_DLY = 2'd1, M_REC = 2'd2, M_PLAY = 2'd3;
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic signed [ACC_W-1:0] SMAX = {4'b0000, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = {4'b1111, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LATCH, READ, ACC, WRITE} state_t;

    state_t state, state_nx;
    logic [2:0]                tcnt;
    logic signed [DATA_W-1:0]  x_q;
    logic [1:0]                mode_q, prev_mode;
    logic [ADDR_W-1:0]         dlen_q;
    logic [GAIN_W-1:0]         fb_q;
    logic [TAPS*GAIN_W-1:0]    tg_q;
    logic [ADDR_W-1:0]         wr_ptr, rec_ptr, play_ptr;
    logic [ADDR_W:0]           fill, loop_len;
    logic                      loop_full, overrun;
    logic signed [ACC_W-1:0]   acc, fbacc, acc_nx, fb_nx;
    logic                      rd_pend, rd_ok, rd_ok_nx;
    logic [2:0]                rd_tap;
    logic [ADDR_W-1:0]         rd_addr, dk;
    logic [GAIN_W-1:0]         tg_sel;
    logic [DATA_W-1:0]         mem [DEPTH];
    logic signed [DATA_W-1:0]  mem_q;
    logic signed [DATA_W-1:0]  data_out_q, wdata;
    logic                      wen;
    logic [ADDR_W-1:0]         waddr;
    logic                      busy_c, out_valid_c;

    // signed sample times unsigned gain, floor-shifted back to sample scale
    function automatic logic signed [ACC_W-1:0] scale(
        input logic signed [DATA_W-1:0] s,
        input logic [GAIN_W-1:0]        g
    );
        logic signed [PW-1:0] se, ge, p;
        se = PW'(s);
        ge = PW'({1'b0, g});
        p  = se * ge;
        return ACC_W'(p >>> GAIN_W);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        if (a > SMAX)      r = SMAX;
        else if (a < SMIN) r = SMIN;
        else               r = a;
        return r[DATA_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.adc_clock) state_nx = LATCH;
            LATCH:   state_nx = READ;
            READ:    if (tcnt == 3'(TAPS - 1)) state_nx = ACC;
            ACC:     state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_c      = (state != IDLE);
        out_valid_c = (state == WRITE);
    end

    // tap address and fill masking; only tap 0 is used in play mode
    always_comb begin
        dk = dlen_q >> tcnt;
        if (dk == '0) dk = ADDR_W'(1);
        rd_addr  = wr_ptr - dk;
        rd_ok_nx = 1'b0;
        if (state == READ) begin
            if (mode_q == M_DLY) begin
                rd_ok_nx = ({1'b0, dk} <= fill);
            end else if (mode_q == M_PLAY && tcnt == 3'd0 && loop_len != '0) begin
                rd_addr  = play_ptr;
                rd_ok_nx = 1'b1;
            end
        end
    end

    always_comb begin
        tg_sel = tg_q[GAIN_W-1:0];
        for (int k = 1; k < TAPS; k++)
            if (32'(rd_tap) == k) tg_sel = tg_q[k*GAIN_W +: GAIN_W];
    end

    // RAM data lags the address by a cycle, so taps are summed one cycle late
    always_comb begin
        acc_nx = acc;
        fb_nx  = fbacc;
        if (rd_pend && rd_ok) begin
            acc_nx = acc + scale(mem_q, tg_sel);
            if (rd_tap == 3'd0) fb_nx = fbacc + scale(mem_q, fb_q);
        end
    end

    always_ff @(posedge clk) begin
        if (state == READ) mem_q <= mem[rd_addr];
        if (state == WRITE && wen && !rst) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt       <= '0;
            x_q        <= '0;
            mode_q     <= M_BYP;
            prev_mode  <= M_BYP;
            dlen_q     <= '0;
            fb_q       <= '0;
            tg_q       <= '0;
            wr_ptr     <= '0;
            rec_ptr    <= '0;
            play_ptr   <= '0;
            fill       <= '0;
            loop_len   <= '0;
            loop_full  <= 1'b0;
            overrun    <= 1'b0;
            acc        <= '0;
            fbacc      <= '0;
            rd_pend    <= 1'b0;
            rd_ok      <= 1'b0;
            rd_tap     <= '0;
            data_out_q <= '0;
            wdata      <= '0;
            waddr      <= '0;
            wen        <= 1'b0;
        end else begin
            rd_pend <= (state == READ);
            rd_ok   <= rd_ok_nx;
            rd_tap  <= tcnt;
            acc     <= acc_nx;
            fbacc   <= fb_nx;
            if (bus.adc_clock && state != IDLE) overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.adc_clock) begin
                        x_q    <= bus.data_in;
                        mode_q <= bus.mode;
                        dlen_q <= bus.delay_len;
                        fb_q   <= bus.fb_gain;
                        tg_q   <= bus.tap_gain;
                    end
                end
                LATCH: begin
                    prev_mode <= mode_q;
                    tcnt      <= '0;
                    acc       <= ACC_W'(x_q);
                    fbacc     <= ACC_W'(x_q);
                    if (mode_q != prev_mode) begin
                        unique case (mode_q)
                            M_DLY: begin
                                // delay reuses the loop RAM, so the loop is lost
                                wr_ptr    <= '0;
                                fill      <= '0;
                                rec_ptr   <= '0;
                                loop_len  <= '0;
                                loop_full <= 1'b0;
                            end
                            M_REC: begin
                                rec_ptr   <= '0;
                                loop_len  <= '0;
                                loop_full <= 1'b0;
                            end
                            M_PLAY:  play_ptr <= '0;
                            default: ;
                        endcase
                    end
                end
                READ: tcnt <= tcnt + 3'd1;
                ACC: begin
                    data_out_q <= sat(acc_nx);
                    wen        <= (mode_q == M_DLY);
                    waddr      <= wr_ptr;
                    wdata      <= sat(fb_nx);
                    if (mode_q == M_REC && !loop_full) begin
                        wen       <= 1'b1;
                        waddr     <= rec_ptr;
                        wdata     <= x_q;
                        loop_len  <= loop_len + 1'b1;
                        loop_full <= (loop_len + 1'b1 == FULL);
                    end
                end
                WRITE: begin
                    if (mode_q == M_DLY) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (fill != FULL) fill <= fill + 1'b1;
                    end
                    if (mode_q == M_REC && wen) rec_ptr <= rec_ptr + 1'b1;
                    if (mode_q == M_PLAY && loop_len != '0) begin
                        if ({1'b0, play_ptr} + 1'b1 == loop_len) play_ptr <= '0;
                        else play_ptr <= play_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.loop_len  = loop_len;
    assign bus.loop_full = loop_full;
    assign bus.overrun   = overrun;
endmodule
